// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin front end for one byte-write, read-first RAM port.
// Turns byte address + access size into a word address and lane enables,
// rejects misaligned or illegal-size accesses, and returns one lane-aligned
// response per accepted request with response back-pressure.
//
// Handshakes: a request transfers on the cycle reqN_valid && reqN_ready; a
// response transfers on the cycle rspN_valid && rspN_ready. reqN_ready may
// depend combinationally on reqN_valid and on the pending owner's rspN_ready.
// Requesters hold their request stable until it is accepted.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // requester 0 (CPU load/store unit)
    input  logic                           req0_valid,
    output logic                           req0_ready,
    input  logic                           req0_we,
    input  logic [1:0]                     req0_size,
    input  logic [ADDR_WIDTH+1:0]          req0_addr,
    input  logic [NUM_COL*COL_WIDTH-1:0]   req0_wdata,
    output logic                           rsp0_valid,
    input  logic                           rsp0_ready,
    output logic [NUM_COL*COL_WIDTH-1:0]   rsp0_rdata,
    output logic                           rsp0_err,
    // requester 1 (debug / program loader)
    input  logic                           req1_valid,
    output logic                           req1_ready,
    input  logic                           req1_we,
    input  logic [1:0]                     req1_size,
    input  logic [ADDR_WIDTH+1:0]          req1_addr,
    input  logic [NUM_COL*COL_WIDTH-1:0]   req1_wdata,
    output logic                           rsp1_valid,
    input  logic                           rsp1_ready,
    output logic [NUM_COL*COL_WIDTH-1:0]   rsp1_rdata,
    output logic                           rsp1_err,
    // RAM port
    output logic                           ram_en,
    output logic [NUM_COL-1:0]             ram_we,
    output logic [ADDR_WIDTH-1:0]          ram_addr,
    output logic [NUM_COL*COL_WIDTH-1:0]   ram_din,
    input  logic [NUM_COL*COL_WIDTH-1:0]   ram_dout,
    // debug: 0 = IDLE, 1 = RESP
    output logic                           dbg_state
);

    localparam int DATA_W = NUM_COL * COL_WIDTH;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    // registered state
    state_t              state_q, state_d;
    logic                rr_ptr_q, rr_ptr_d;     // favoured requester under contention
    logic                owner_q, owner_d;       // requester owning the pending response
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [1:0]          off_q, off_d;
    logic                err_q, err_d;
    logic                first_q, first_d;       // response is in its first visible cycle
    logic [DATA_W-1:0]   hold_q, hold_d;         // read data kept for stalled responses

    // arbitration
    logic                owner_rsp_ready;
    logic                can_grant;
    logic                both_valid;
    logic                grant0, grant1, grant_any;

    // selected-request decode
    logic                sel_we;
    logic [1:0]          sel_size;
    logic [ADDR_WIDTH+1:0] sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [1:0]          sel_off;
    logic                sel_legal;
    logic [NUM_COL-1:0]  sel_lanes;
    logic [DATA_W-1:0]   sel_din;

    // response data path
    logic [DATA_W-1:0]   shifted;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_accept;

    // Grant decision: free when idle, or when the pending response leaves this cycle.
    always_comb begin
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
        rsp_accept      = (state_q == S_RESP) && owner_rsp_ready;
        can_grant       = rst_n && ((state_q == S_IDLE) || owner_rsp_ready);
        both_valid      = req0_valid && req1_valid;
        grant0          = 1'b0;
        grant1          = 1'b0;
        if (can_grant) begin
            if (both_valid) begin
                if (rr_ptr_q) grant1 = 1'b1;
                else          grant0 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
        grant_any  = grant0 || grant1;
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Decode the winning request: alignment check, lane enables and lane-placed data.
    always_comb begin
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_size  = grant1 ? req1_size  : req0_size;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
        sel_off   = sel_addr[1:0];
        sel_legal = 1'b0;
        sel_lanes = '0;
        sel_din   = sel_wdata;
        case (sel_size)
            2'b00: begin
                sel_legal = 1'b1;
                sel_lanes = 4'b0001 << sel_off;
                sel_din   = {4{sel_wdata[7:0]}};
            end
            2'b01: begin
                sel_legal = !sel_off[0];
                sel_lanes = 4'b0011 << sel_off;
                sel_din   = {2{sel_wdata[15:0]}};
            end
            2'b10: begin
                sel_legal = (sel_off == 2'b00);
                sel_lanes = 4'b1111;
                sel_din   = sel_wdata;
            end
            default: begin
                sel_legal = 1'b0;
                sel_lanes = '0;
                sel_din   = sel_wdata;
            end
        endcase
    end

    // RAM port drive: only legal granted accesses touch the RAM; idle port drives zeros.
    always_comb begin
        ram_en   = grant_any && sel_legal;
        ram_we   = '0;
        ram_addr = '0;
        ram_din  = '0;
        if (ram_en) begin
            ram_addr = sel_addr[ADDR_WIDTH+1:2];
            ram_din  = sel_din;
            if (sel_we) ram_we = sel_lanes;
        end
    end

    // Read data extraction: shift the addressed lane down, mask to size, zero stores/errors.
    always_comb begin
        shifted   = ram_dout >> {off_q, 3'b000};
        load_data = '0;
        if (!we_q && !err_q) begin
            case (size_q)
                2'b00:   load_data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
                2'b01:   load_data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
                default: load_data = shifted;
            endcase
        end
        // the RAM output is only trusted in the response's first cycle
        rsp_data = first_q ? load_data : hold_q;
    end

    // Response outputs: routed to the owner, zero elsewhere.
    always_comb begin
        rsp0_valid = (state_q == S_RESP) && !owner_q;
        rsp1_valid = (state_q == S_RESP) &&  owner_q;
        rsp0_rdata = rsp0_valid ? rsp_data : '0;
        rsp1_rdata = rsp1_valid ? rsp_data : '0;
        rsp0_err   = rsp0_valid && err_q;
        rsp1_err   = rsp1_valid && err_q;
        dbg_state  = state_q;
    end

    // Next-state: latch the granted access, retire accepted responses, keep stalls frozen.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        we_d     = we_q;
        size_d   = size_q;
        off_d    = off_q;
        err_d    = err_q;
        first_d  = 1'b0;
        hold_d   = hold_q;
        if ((state_q == S_RESP) && first_q) begin
            hold_d = load_data;
        end
        if (grant_any) begin
            state_d = S_RESP;
            owner_d = grant1;
            we_d    = sel_we;
            size_d  = sel_size;
            off_d   = sel_off;
            err_d   = !sel_legal;
            first_d = 1'b1;
            if (both_valid) rr_ptr_d = !grant1;
        end else if (rsp_accept) begin
            state_d = S_IDLE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= 1'b0;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            err_q    <= 1'b0;
            first_q  <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            size_q   <= size_d;
            off_q    <= off_d;
            err_q    <= err_d;
            first_q  <= first_d;
            hold_q   <= hold_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a read-first byte-write RAM behind the port,
// directed scenarios, then randomized traffic checked every cycle against a
// transaction-level reference model (pending response, rr pointer, shadow memory).
module tb_ram_port_arbiter;

  localparam int AW = 16;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [1:0]  req0_size;
  logic [AW+1:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic [31:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we;
  logic [1:0]  req1_size;
  logic [AW+1:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] rsp1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        dbg_state;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .NUM_COL(4), .COL_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_size(req0_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_size(req1_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM behind the port: read-first, byte write enables, output held while disabled
  logic [31:0] env_mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= env_mem[ram_addr[7:0]];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) env_mem[ram_addr[7:0]][8*i +: 8] <= ram_din[8*i +: 8];
    end
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];   // expected grant order in the contention test

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  logic [31:0] ref_mem [256];
  logic        m_pend, m_owner, m_err, m_rr;
  logic [31:0] m_data;
  logic        acc0, acc1;
  logic [31:0] grant_q[$];

  // one cycle of the reference model, evaluated at the negedge with inputs stable
  task automatic model_step();
    logic        allowed, g_any, g, we, legal;
    logic [1:0]  sz;
    logic [AW+1:0] a;
    logic [31:0] wd, bm, lanes;
    logic [63:0] dmask, sh;
    int          off, nbytes;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (!rst_n) begin
      m_pend = 1'b0;
      m_rr   = 1'b0;
      check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
      check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
      check("rst_ram_en", {31'b0, ram_en}, 32'd0);
      check("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      return;
    end
    allowed = !m_pend || (m_owner ? rsp1_ready : rsp0_ready);
    g_any = 1'b0;
    g = 1'b0;
    if (allowed) begin
      if (req0_valid && req1_valid) begin g_any = 1'b1; g = m_rr; end
      else if (req0_valid) begin g_any = 1'b1; g = 1'b0; end
      else if (req1_valid) begin g_any = 1'b1; g = 1'b1; end
    end
    acc0 = g_any && !g;
    acc1 = g_any && g;
    check("req0_ready", {31'b0, req0_ready}, {31'b0, acc0});
    check("req1_ready", {31'b0, req1_ready}, {31'b0, acc1});
    check("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, m_pend && !m_owner});
    check("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, m_pend && m_owner});
    check("rsp0_rdata", rsp0_rdata, (m_pend && !m_owner) ? m_data : 32'd0);
    check("rsp1_rdata", rsp1_rdata, (m_pend && m_owner) ? m_data : 32'd0);
    check("rsp0_err", {31'b0, rsp0_err}, {31'b0, m_pend && !m_owner && m_err});
    check("rsp1_err", {31'b0, rsp1_err}, {31'b0, m_pend && m_owner && m_err});

    we = g ? req1_we : req0_we;
    sz = g ? req1_size : req0_size;
    a  = g ? req1_addr : req0_addr;
    wd = g ? req1_wdata : req0_wdata;
    off = int'(a[1:0]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    legal = (sz != 2'd3) && ((off % nbytes) == 0);
    lanes = ((32'd1 << nbytes) - 32'd1) << off;
    bm = '0;
    for (int i = 0; i < 4; i++) if (lanes[i]) bm[8*i +: 8] = 8'hFF;
    dmask = (64'd1 << (8 * nbytes)) - 64'd1;
    sh = ({32'd0, wd} & dmask) << (8 * off);

    check("ram_en", {31'b0, ram_en}, {31'b0, g_any && legal});
    check("ram_addr", {16'b0, ram_addr}, (g_any && legal) ? {16'b0, a[AW+1:2]} : 32'd0);
    check("ram_we", {28'b0, ram_we}, (g_any && legal && we) ? lanes : 32'd0);
    if (g_any && legal && we) check("ram_din_lanes", ram_din & bm, sh[31:0] & bm);
    else if (!(g_any && legal)) check("ram_din_idle", ram_din, 32'd0);

    if (g_any) begin
      grant_q.push_back({31'b0, g});
      if (req0_valid && req1_valid) m_rr = !g;
      m_pend  = 1'b1;
      m_owner = g;
      m_err   = !legal;
      m_data  = '0;
      if (legal && we) begin
        for (int i = 0; i < nbytes; i++)
          ref_mem[a[9:2]][8*(off+i) +: 8] = wd[8*i +: 8];
      end else if (legal) begin
        sh = ({32'd0, ref_mem[a[9:2]]} >> (8 * off)) & dmask;
        m_data = sh[31:0];
      end
    end else if (m_pend && allowed) begin
      m_pend = 1'b0;
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int n, input logic v, input logic we, input logic [1:0] sz,
                           input logic [AW+1:0] a, input logic [31:0] d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic rand_req(input int n);
    logic [1:0]    sz;
    logic [AW+1:0] a;
    sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    a  = ($urandom_range(0, 7) == 0) ? (AW+2)'($urandom) : (AW+2)'($urandom_range(0, 63));
    if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
    drive_req(n, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), sz, a, $urandom);
  endtask

  task automatic set_word(input int idx, input logic [31:0] v);
    env_mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  logic [31:0] word0_init;

  initial begin
    rst_n = 1'b0;
    drive_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
    drive_req(1, 1'b0, 1'b0, 2'd0, '0, '0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    m_pend = 1'b0; m_owner = 1'b0; m_err = 1'b0; m_rr = 1'b0; m_data = '0;
    acc0 = 1'b0; acc1 = 1'b0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    set_word(4, 32'hDEADBEEF);
    set_word(8, 32'h12345678);
    word0_init = env_mem[0];
    ram_dout = '0;

    // reset state, including a valid request held off by reset
    repeat (2) @(posedge clk);
    #1;
    drive_req(0, 1'b1, 1'b1, 2'd2, 18'h10, 32'h1);
    #1;
    check("reset_req0_ready", {31'b0, req0_ready}, 32'd0);
    check("reset_ram_en", {31'b0, ram_en}, 32'd0);
    check("reset_ram_we", {28'b0, ram_we}, 32'd0);
    check("reset_ram_addr", {16'b0, ram_addr}, 32'd0);
    check("reset_ram_din", ram_din, 32'd0);
    check("reset_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    check("reset_rsp_err", {30'b0, rsp1_err, rsp0_err}, 32'd0);
    check("reset_rsp_rdata", rsp0_rdata | rsp1_rdata, 32'd0);
    drive_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // load word 0x0010
    drive_req(0, 1'b1, 1'b0, 2'd2, 18'h10, 32'd0);
    #1;
    check("t1_ram_en", {31'b0, ram_en}, 32'd1);
    check("t1_ram_addr", {16'b0, ram_addr}, 32'd4);
    check("t1_ram_we", {28'b0, ram_we}, 32'd0);
    cycle();
    drive_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
    check("t1_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    check("t1_rsp0_rdata", rsp0_rdata, 32'hDEADBEEF);
    check("t1_rsp0_err", {31'b0, rsp0_err}, 32'd0);

    // store byte 0xAB at 0x0013, then load it back-to-back
    drive_req(0, 1'b1, 1'b1, 2'd0, 18'h13, 32'h000000AB);
    #1;
    check("t2_ram_we", {28'b0, ram_we}, 32'b1000);
    check("t2_ram_din_hi", {24'b0, ram_din[31:24]}, 32'hAB);
    cycle();
    drive_req(0, 1'b1, 1'b0, 2'd0, 18'h13, 32'd0);
    cycle();
    drive_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
    check("t2_load_byte", rsp0_rdata, 32'h000000AB);
    cycle();

    // misaligned half and illegal size from req1
    drive_req(1, 1'b1, 1'b1, 2'd1, 18'h1, 32'h5555);
    #1;
    check("t3_ram_en", {31'b0, ram_en}, 32'd0);
    cycle();
    drive_req(1, 1'b1, 1'b0, 2'd3, 18'h0, 32'd0);
    check("t3_half_err", {31'b0, rsp1_err}, 32'd1);
    check("t3_half_rdata", rsp1_rdata, 32'd0);
    cycle();
    drive_req(1, 1'b0, 1'b0, 2'd0, '0, '0);
    check("t3_size3_err", {31'b0, rsp1_err}, 32'd1);
    cycle();
    check("t3_ram_unchanged", env_mem[0], word0_init);

    // contention: four cycles with both valid
    drive_req(0, 1'b1, 1'b0, 2'd2, 18'h20, 32'd0);
    drive_req(1, 1'b1, 1'b0, 2'd2, 18'h24, 32'd0);
    grant_q.delete();
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    repeat (4) cycle();
    drive_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
    drive_req(1, 1'b0, 1'b0, 2'd0, '0, '0);
    check("t4_grant_count", grant_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) check("t4_grant_order", grant_q[i], exp_q[i]);
    cycle();

    // back-pressure on rsp0 while req1 waits
    drive_req(0, 1'b1, 1'b0, 2'd2, 18'h20, 32'd0);
    cycle();
    drive_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
    drive_req(1, 1'b1, 1'b0, 2'd2, 18'h24, 32'd0);
    rsp0_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_hold_rdata", rsp0_rdata, 32'h12345678);
      check("t5_req1_blocked", {31'b0, req1_ready}, 32'd0);
      check("t5_ram_idle", {31'b0, ram_en}, 32'd0);
      cycle();
    end
    rsp0_ready = 1'b1;
    #1;
    check("t5_req1_granted", {31'b0, req1_ready}, 32'd1);
    cycle();
    drive_req(1, 1'b0, 1'b0, 2'd0, '0, '0);
    cycle();

    // reset with a response pending
    drive_req(0, 1'b1, 1'b0, 2'd2, 18'h10, 32'd0);
    cycle();
    drive_req(1, 1'b1, 1'b0, 2'd2, 18'h24, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    check("t6_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    check("t6_ram_en", {31'b0, ram_en}, 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    m_pend = 1'b0;
    m_rr = 1'b0;
    #1;
    check("t6_req0_first", {31'b0, req0_ready}, 32'd1);
    check("t6_req1_wait", {31'b0, req1_ready}, 32'd0);
    cycle();
    drive_req(0, 1'b0, 1'b0, 2'd0, '0, '0);
    drive_req(1, 1'b0, 1'b0, 2'd0, '0, '0);
    cycle();

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if (!req0_valid || acc0) rand_req(0);
      if (!req1_valid || acc1) rand_req(1);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
